// File: rtl/dst40_round_engine.sv
// rtl/dst40_round_engine.sv - DST40 round sequencer around an external F network
// One round per RUN cycle; the key LFSR steps every KEY_STEP rounds on the same edge.
module dst40_round_engine #(
  parameter int ROUNDS   = 200,
  parameter int KEY_STEP = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [39:0] challenge,
  input  logic [39:0] key,
  output logic [39:0] f_chal,
  output logic [39:0] f_key,
  input  logic [1:0]  f_out,
  output logic        busy,
  output logic        done,
  output logic [23:0] sig
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [2:0] LAST_KSTEP = 3'(KEY_STEP - 1);

  state_t      state;
  logic [7:0]  rcnt;
  logic [2:0]  kcnt;
  logic [39:0] chal;
  logic [39:0] keyr;

  assign f_chal = chal;
  assign f_key  = keyr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      chal  <= '0;
      keyr  <= '0;
      rcnt  <= '0;
      kcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sig   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            chal  <= challenge;
            keyr  <= key;
            rcnt  <= '0;
            kcnt  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            // Aborted run leaves chal/keyr frozen and sig untouched.
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            chal <= {f_out ^ chal[1:0], chal[39:2]};
            rcnt <= rcnt + 8'd1;
            if (kcnt == LAST_KSTEP) begin
              keyr <= {keyr[0] ^ keyr[2] ^ keyr[19] ^ keyr[21], keyr[39:1]};
              kcnt <= '0;
            end else begin
              kcnt <= kcnt + 3'd1;
            end
            if (rcnt == LAST_ROUND) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          sig   <= chal[23:0];
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
